// File: rtl/si5340_i2c_target.sv
// Si5340-style I2C register target: device address match, register pointer with
// auto-increment, internal page register (0x01), {page,reg} strobes to a register array.
module si5340_i2c_target #(
    parameter logic [6:0]  DEV_ADDR   = 7'h74,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oen_o,
    output logic                      wr_en_o,
    output logic                      rd_en_o,
    output logic [2*DATA_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    output logic [DATA_WIDTH-1:0]     page_o,
    output logic                      busy_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [DATA_WIDTH-1:0] PAGE_REG = DATA_WIDTH'(1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_REG       = 4'd3;
    localparam logic [3:0] S_REG_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d, scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt, ptr, ptr_nxt, page_nxt, rx_byte;
    logic                  rw, rw_nxt, nack, nack_nxt;
    logic                  rd_pend, rd_pend_nxt, load_pend, load_pend_nxt;
    logic                  drive_pend, drive_pend_nxt;
    logic                  sda_oen_nxt, wr_en_nxt, rd_en_nxt, busy_nxt;
    logic [2*DATA_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;

    // Line synchronizers plus one history stage for edge/condition detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            nack       <= 1'b0;
            rd_pend    <= 1'b0;
            load_pend  <= 1'b0;
            drive_pend <= 1'b0;
            sda_oen_o  <= 1'b1;
            wr_en_o    <= 1'b0;
            rd_en_o    <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            page_o     <= '0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            ptr        <= ptr_nxt;
            rw         <= rw_nxt;
            nack       <= nack_nxt;
            rd_pend    <= rd_pend_nxt;
            load_pend  <= load_pend_nxt;
            drive_pend <= drive_pend_nxt;
            sda_oen_o  <= sda_oen_nxt;
            wr_en_o    <= wr_en_nxt;
            rd_en_o    <= rd_en_nxt;
            addr_o     <= addr_nxt;
            wdata_o    <= wdata_nxt;
            page_o     <= page_nxt;
            busy_o     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shreg_nxt      = shreg;
        ptr_nxt        = ptr;
        page_nxt       = page_o;
        rw_nxt         = rw;
        nack_nxt       = nack;
        rd_pend_nxt    = 1'b0;
        load_pend_nxt  = rd_pend;
        drive_pend_nxt = 1'b0;
        sda_oen_nxt    = sda_oen_o;
        wr_en_nxt      = 1'b0;
        rd_en_nxt      = 1'b0;
        addr_nxt       = addr_o;
        wdata_nxt      = wdata_o;
        busy_nxt       = busy_o;
        rx_byte        = {shreg[DATA_WIDTH-2:0], sda_s};

        if (start_det || stop_det) begin
            state_nxt     = start_det ? S_ADDR : S_IDLE;
            cnt_nxt       = '0;
            sda_oen_nxt   = 1'b1;
            busy_nxt      = 1'b0;
            load_pend_nxt = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise && cnt != CNT_W'(8)) begin
                        shreg_nxt = rx_byte;
                        cnt_nxt   = cnt + CNT_W'(1);
                        // Write commits on the edge sampling bit 0 so a partial byte never strobes
                        if (state == S_WDATA && cnt == CNT_W'(7)) begin
                            ptr_nxt = ptr + DATA_WIDTH'(1);
                            if (ptr == PAGE_REG) begin
                                page_nxt = rx_byte;
                            end else begin
                                wr_en_nxt = 1'b1;
                                addr_nxt  = {page_o, ptr};
                                wdata_nxt = rx_byte;
                            end
                        end
                    end else if (scl_fall && cnt == CNT_W'(8)) begin
                        cnt_nxt = '0;
                        if (state == S_ADDR && shreg[DATA_WIDTH-1:1] != DEV_ADDR) begin
                            state_nxt = S_IGNORE;
                        end else begin
                            sda_oen_nxt = 1'b0;
                            if (state == S_ADDR) begin
                                state_nxt = S_ADDR_ACK;
                                busy_nxt  = 1'b1;
                                rw_nxt    = shreg[0];
                            end else if (state == S_REG) begin
                                state_nxt = S_REG_ACK;
                                ptr_nxt   = shreg;
                            end else begin
                                state_nxt = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK, S_RDATA_ACK: begin
                    if (state == S_RDATA_ACK && scl_rise) begin
                        nack_nxt = sda_s;
                    end
                    if (scl_fall) begin
                        sda_oen_nxt = 1'b1;
                        cnt_nxt     = '0;
                        if (state == S_RDATA_ACK && nack) begin
                            state_nxt = S_IGNORE;
                        end else if ((state == S_ADDR_ACK && rw) || state == S_RDATA_ACK) begin
                            // Launch the next read byte; page register is served locally
                            state_nxt   = S_RDATA;
                            rd_pend_nxt = 1'b1;
                            if (ptr != PAGE_REG) begin
                                rd_en_nxt = 1'b1;
                                addr_nxt  = {page_o, ptr};
                            end
                        end else if (state == S_ADDR_ACK) begin
                            state_nxt = S_REG;
                        end else begin
                            state_nxt = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (load_pend) begin
                        shreg_nxt      = (ptr == PAGE_REG) ? page_o : rdata_i;
                        ptr_nxt        = ptr + DATA_WIDTH'(1);
                        drive_pend_nxt = 1'b1;
                    end
                    if (drive_pend) begin
                        sda_oen_nxt = shreg[DATA_WIDTH-1];
                    end
                    if (scl_rise && cnt != CNT_W'(8)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else if (scl_fall && cnt == CNT_W'(8)) begin
                        sda_oen_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = S_RDATA_ACK;
                    end else if (scl_fall && cnt != CNT_W'(0)) begin
                        shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
                        sda_oen_nxt = shreg[DATA_WIDTH-2];
                    end
                end
                S_IDLE, S_IGNORE: begin
                    sda_oen_nxt = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Directed bench for si5340_i2c_target: bit-banged I2C master, register-array read model,
// strobe logging and immediate-assertion checks.
module tb_si5340_i2c_target;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oen, wr_en, rd_en, busy;
    logic [15:0] addr;
    logic [7:0]  wdata, page;
    logic [7:0]  rdata = 8'h00;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [15:0] wr_addr_log [16];
    logic [7:0]  wr_data_log [16];
    logic [15:0] rd_addr_log [16];

    logic       ack;
    logic [7:0] rbyte;
    logic [7:0] abyte;

    assign sda_bus = sda_m & sda_oen;

    always #5 clk = ~clk;

    si5340_i2c_target #(.DEV_ADDR(7'h74), .DATA_WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oen_o (sda_oen),
        .wr_en_o   (wr_en),
        .rd_en_o   (rd_en),
        .addr_o    (addr),
        .wdata_o   (wdata),
        .rdata_i   (rdata),
        .page_o    (page),
        .busy_o    (busy)
    );

    // Register array answers the cycle after rd_en and only for that one cycle
    always @(posedge clk) begin
        rdata <= rd_en ? (addr[7:0] ^ 8'hA5) : 8'h00;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = addr;
                wr_data_log[wr_cnt] = wdata;
            end
            wr_cnt++;
        end
        if (rd_en) begin
            if (rd_cnt < 16) rd_addr_log[rd_cnt] = addr;
            rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q(); wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = sda_bus;  wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic a);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(a);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_sda_oen", 16'(sda_oen), 16'h1);
        chk("rst_strobes", {14'h0, wr_en, rd_en}, 16'h0);
        chk("rst_addr", addr, 16'h0000);
        chk("rst_wdata_page", {wdata, page}, 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        wait_q();

        // Two-byte write with auto-increment
        i2c_start();
        write_byte(8'hE8, ack); chk("w1_ack_addr", 16'(ack), 16'h0);
        chk("w1_busy", 16'(busy), 16'h1);
        write_byte(8'h0B, ack); chk("w1_ack_reg", 16'(ack), 16'h0);
        write_byte(8'h5A, ack); chk("w1_ack_d0", 16'(ack), 16'h0);
        write_byte(8'hA5, ack); chk("w1_ack_d1", 16'(ack), 16'h0);
        i2c_stop();
        chk("w1_busy_after_stop", 16'(busy), 16'h0);
        chk("w1_wr_count", 16'(wr_cnt), 16'd2);
        chk("w1_addr0", wr_addr_log[0], 16'h000B);
        chk("w1_data0", 16'(wr_data_log[0]), 16'h005A);
        chk("w1_addr1", wr_addr_log[1], 16'h000C);
        chk("w1_data1", 16'(wr_data_log[1]), 16'h00A5);

        // Page register write, then a paged write
        i2c_start();
        write_byte(8'hE8, ack);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack); chk("pg_ack", 16'(ack), 16'h0);
        i2c_stop();
        chk("pg_page", 16'(page), 16'h0002);
        chk("pg_no_strobe", 16'(wr_cnt), 16'd2);
        i2c_start();
        write_byte(8'hE8, ack);
        write_byte(8'h1F, ack);
        write_byte(8'h33, ack);
        i2c_stop();
        chk("pg_wr_count", 16'(wr_cnt), 16'd3);
        chk("pg_addr", wr_addr_log[2], 16'h021F);
        chk("pg_data", 16'(wr_data_log[2]), 16'h0033);

        // Pointer set, repeated START, 3-byte read with pointer wrap
        i2c_start();
        write_byte(8'hE8, ack);
        write_byte(8'hFE, ack);
        i2c_start();
        write_byte(8'hE9, ack); chk("rd_ack_addr", 16'(ack), 16'h0);
        read_byte(rbyte, 1'b0); chk("rd_data0", 16'(rbyte), 16'h005B);
        read_byte(rbyte, 1'b0); chk("rd_data1", 16'(rbyte), 16'h005A);
        read_byte(rbyte, 1'b1); chk("rd_data2", 16'(rbyte), 16'h00A5);
        i2c_stop();
        chk("rd_count", 16'(rd_cnt), 16'd3);
        chk("rd_addr0", rd_addr_log[0], 16'h02FE);
        chk("rd_addr1", rd_addr_log[1], 16'h02FF);
        chk("rd_addr2", rd_addr_log[2], 16'h0200);

        // Foreign address: no ACK, no strobes, not busy
        i2c_start();
        write_byte(8'hEA, ack); chk("na_ack", 16'(ack), 16'h1);
        chk("na_busy", 16'(busy), 16'h0);
        write_byte(8'h10, ack); chk("na_ack2", 16'(ack), 16'h1);
        i2c_stop();
        chk("na_strobes", 16'(wr_cnt + rd_cnt), 16'd6);

        // STOP in the middle of a data byte, then a normal write
        i2c_start();
        write_byte(8'hE8, ack);
        write_byte(8'h20, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        chk("ab_no_strobe", 16'(wr_cnt), 16'd3);
        i2c_start();
        write_byte(8'hE8, ack);
        write_byte(8'h20, ack);
        write_byte(8'h11, ack); chk("ab_ack", 16'(ack), 16'h0);
        i2c_stop();
        chk("ab_wr_count", 16'(wr_cnt), 16'd4);
        chk("ab_addr", wr_addr_log[3], 16'h0220);
        chk("ab_data", 16'(wr_data_log[3]), 16'h0011);

        // Reset while the target drives the address ACK
        i2c_start();
        abyte = 8'hE8;
        for (int i = 7; i >= 0; i--) write_bit(abyte[i]);
        chk("rs_ack_driven", 16'(sda_oen), 16'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_sda_released", 16'(sda_oen), 16'h1);
        chk("rs_page", 16'(page), 16'h0000);
        chk("rs_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        chk("rs_no_ack", 16'(sda_bus), 16'h1);
        scl_m = 1'b0; wait_q();
        i2c_stop();
        i2c_start();
        write_byte(8'hE8, ack); chk("rs_fresh_ack", 16'(ack), 16'h0);
        write_byte(8'h05, ack);
        write_byte(8'h44, ack);
        i2c_stop();
        chk("rs_wr_count", 16'(wr_cnt), 16'd5);
        chk("rs_addr", wr_addr_log[4], 16'h0005);
        chk("rs_data", 16'(wr_data_log[4]), 16'h0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/si5340_i2c_target.md
# si5340_i2c_target

I2C target (slave) that models the Si5340 serial register interface: it answers its 7-bit device address, accepts a register pointer byte, then performs byte writes or reads with auto-increment. It maintains the Si5340 page register (0x01) internally and exposes every other access as a 16-bit {page, register} strobe to an attached register array. It is the responder end of the config-loader I2C link, used as the DUT partner in loader simulation and as an FPGA-side target.

## Interface
- DEV_ADDR, 7'h74, 7-bit device address matched after START.
- DATA_WIDTH, 8, byte width; fixed at 8, other values unsupported.
- clk_i  in  1  system clock, at least 8x SCL frequency.
- rst_i  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL line input (asynchronous).
- sda_i  in  1  SDA line input (asynchronous).
- sda_oen_o  out  1  SDA output enable, active low; when 0 the pad drives 0. SCL is never driven (no clock stretching).
- wr_en_o  out  1  one-cycle write strobe.
- rd_en_o  out  1  one-cycle read request.
- addr_o  out  16  {page, register} for wr_en_o / rd_en_o.
- wdata_o  out  8  write data, valid with wr_en_o.
- rdata_i  in  8  read data, sampled exactly one cycle after rd_en_o.
- page_o  out  8  current page register value.
- busy_o  out  1  high from address match until STOP/START.

## Operation
- scl_i/sda_i pass through 2-FF synchronizers plus one history FF; all decisions use the synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognized in any state; START (incl. repeated) → ADDR, STOP → IDLE. Both release SDA.
- Bits are sampled on detected SCL rising edge; SDA is changed only on the cycle after a detected SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits MSB-first. Match of bits[7:1] with DEV_ADDR → ADDR_ACK (drive 0 for one SCL period); else → IGNORE (SDA released until next START/STOP).
- After ADDR_ACK: R/W=0 → REG; R/W=1 → RDATA.
- REG: byte loads the register pointer; ACK; → WDATA.
- WDATA: each byte is ACKed. Pointer 0x01: page_o ← byte, no wr_en_o. Other pointers: wr_en_o pulse with addr_o={page_o,ptr}, wdata_o=byte, issued on the SCL rising edge sampling bit 0. Pointer then increments.
- RDATA: on the SCL falling edge ending the ACK (ADDR_ACK or master ACK), rd_en_o pulses with addr_o={page_o,ptr} unless ptr=0x01 (page_o used, no rd_en_o). Shift register loads from rdata_i the next cycle; MSB driven the cycle after. Pointer increments at byte load.
- RDATA_ACK: SDA released; master ACK (0) → RDATA; NACK (1) → IGNORE until STOP/START.
- Pointer increment is 8-bit, wraps 0xFF→0x00; page unchanged.
- Pointer and page_o persist across transactions; a read with no preceding REG byte uses the current pointer.

## Timing
- Reset values: sda_oen_o=1, wr_en_o=0, rd_en_o=0, addr_o=0, wdata_o=0, page_o=0, busy_o=0, pointer=0, state IDLE.
- Reset mid-transfer: SDA released on the cycle after rst_i is sampled; the next transaction needs a fresh START.
- Line-to-decision latency: 3 clk_i cycles (synchronizer + edge detect).
- wr_en_o/rd_en_o are single-cycle; at most one per byte.
- ACK/data drive: SDA changes 1 cycle after detected SCL fall, held until the next detected SCL fall.
- busy_o rises on the ADDR_ACK entry cycle and falls on the STOP/START-detect cycle.
- START/STOP during any byte aborts it: no strobe for a partial byte.

## Test plan
- Write 0x74/W, reg 0x0B, data 0x5A, 0xA5, STOP → ACK on all 4 bytes; wr_en_o at {0x00,0x0B}=0x5A, then {0x00,0x0C}=0xA5.
- Write reg 0x01 = 0x02, then reg 0x1F = 0x33 → page_o=0x02, no strobe for 0x01; wr_en_o {0x02,0x1F}=0x33.
- Write pointer 0xFE, repeated START 0x74/R, 3 bytes, NACK last → rd_en_o at 0x02FE, 0x02FF, 0x0200 (wrap); SDA bits match rdata_i.
- Address 0x75/W → no ACK (SDA stays released), no strobes, busy_o=0.
- STOP after 4 bits of a data byte → no wr_en_o; next transaction works normally.
- rst_i asserted while target drives ACK → sda_oen_o=1 next cycle, page_o=0, state IDLE.
